// File: rtl/mmio_port_responder.sv
// Memory-mapped I/O port block: output latch, synchronized input port with change
// detect, and a free-running compare counter with level interrupt.
module mmio_port_responder #(
    parameter logic [31:0] BASE_ADDRESS = 32'h1001_0400
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [7:0]  PortIn,
    output logic [31:0] ReadData,
    output logic        IOHit,
    output logic [31:0] PortOut,
    output logic        IRQ
);

    localparam logic [2:0] IDX_OUT    = 3'd0;
    localparam logic [2:0] IDX_IN     = 3'd1;
    localparam logic [2:0] IDX_STATUS = 3'd2;
    localparam logic [2:0] IDX_CTRL   = 3'd3;
    localparam logic [2:0] IDX_COUNT  = 3'd4;
    localparam logic [2:0] IDX_CMP    = 3'd5;

    logic [31:0] out_q, out_d;
    logic [31:0] count_q, count_d;
    logic [31:0] cmp_q, cmp_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic [1:0]  status_q, status_d;
    logic [7:0]  s1_q, s2_q, s3_q;

    logic [2:0]  idx;
    logic        wr_en;
    logic [5:0]  wr_sel;
    logic        run, autoclr;
    logic        chg_evt, match_evt;
    logic [1:0]  evt;
    logic [31:0] rd_val;

    assign idx     = Address[4:2];
    assign IOHit   = (Address[31:5] == BASE_ADDRESS[31:5]) && (Address[1:0] == 2'b00)
                     && (idx <= IDX_CMP);
    assign wr_en   = MemWrite & IOHit;
    assign run     = ctrl_q[2];
    assign autoclr = ctrl_q[3];

    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_wr_sel
            assign wr_sel[gi] = wr_en && (idx == 3'(gi));
        end
    endgenerate

    assign chg_evt   = (s2_q != s3_q);
    assign match_evt = run && (count_q == cmp_q);
    assign evt       = {match_evt, chg_evt};

    // A fresh event outranks a write-1-clear landing in the same cycle.
    generate
        for (gi = 0; gi < 2; gi++) begin : g_status
            assign status_d[gi] = evt[gi] | (status_q[gi] & ~(wr_sel[IDX_STATUS] & WriteData[gi]));
        end
    endgenerate

    always_comb begin
        out_d   = wr_sel[IDX_OUT]  ? WriteData       : out_q;
        ctrl_d  = wr_sel[IDX_CTRL] ? WriteData[3:0]  : ctrl_q;
        cmp_d   = wr_sel[IDX_CMP]  ? WriteData       : cmp_q;
        count_d = count_q;
        // A software store to COUNT wins over increment and auto-clear.
        if (wr_sel[IDX_COUNT]) begin
            count_d = WriteData;
        end else if (run) begin
            if (match_evt && autoclr) begin
                count_d = 32'd0;
            end else begin
                count_d = count_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q    <= 32'd0;
            count_q  <= 32'd0;
            cmp_q    <= 32'hFFFF_FFFF;
            ctrl_q   <= 4'd0;
            status_q <= 2'd0;
            s1_q     <= 8'd0;
            s2_q     <= 8'd0;
            s3_q     <= 8'd0;
        end else begin
            out_q    <= out_d;
            count_q  <= count_d;
            cmp_q    <= cmp_d;
            ctrl_q   <= ctrl_d;
            status_q <= status_d;
            s1_q     <= PortIn;
            s2_q     <= s1_q;
            s3_q     <= s2_q;
        end
    end

    always_comb begin
        rd_val = 32'd0;
        case (idx)
            IDX_OUT:    rd_val = out_q;
            IDX_IN:     rd_val = {24'd0, s2_q};
            IDX_STATUS: rd_val = {30'd0, status_q};
            IDX_CTRL:   rd_val = {28'd0, ctrl_q};
            IDX_COUNT:  rd_val = count_q;
            IDX_CMP:    rd_val = cmp_q;
            default:    rd_val = 32'd0;
        endcase
        ReadData = (MemRead && IOHit) ? rd_val : 32'd0;
    end

    assign PortOut = out_q;
    assign IRQ     = (status_q[0] & ctrl_q[0]) | (status_q[1] & ctrl_q[1]);

endmodule
